// File: rtl/tron_mem_pkg.sv
// Shared types and defaults for the Tron unified-memory port: owner encoding and read-return tag.
package tron_mem_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_VID = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line carrying {valid, owner} alongside each memory read so returning data can be routed.
module rd_tag_pipe
    import tron_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [DEPTH];

    // Reset empties the pipe so reads in flight at reset never produce an rvalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '{default: '0};
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between the CPU (fixed priority) and video scanout (bounded wait).
module mem_port_arbiter
    import tron_mem_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int READ_LAT     = 1,
    parameter int VID_MAX_WAIT = 4,
    localparam int WAIT_W      = $clog2(VID_MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [WAIT_W-1:0] vid_wait
);

    logic [WAIT_W-1:0] wait_q;
    logic              vid_starved;
    tag_t              tag_in;
    tag_t              tag_out;

    assign vid_starved = (wait_q == WAIT_W'(VID_MAX_WAIT));

    // Grants are combinational so the winning address reaches memory in the request cycle.
    assign vid_gnt   = ~reset & vid_req & (~cpu_req | vid_starved);
    assign cpu_gnt   = ~reset & cpu_req & ~vid_gnt;
    assign cpu_stall = ~reset & cpu_req & ~cpu_gnt;

    assign mem_addr  = vid_gnt ? vid_addr : cpu_addr;
    assign mem_wdata = cpu_wdata;
    assign mem_we    = cpu_gnt & cpu_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else if (~vid_req || vid_gnt) begin
            wait_q <= '0;
        end else if (!vid_starved) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    assign vid_wait = wait_q;

    assign tag_in.valid = (cpu_gnt & ~cpu_we) | vid_gnt;
    assign tag_in.owner = vid_gnt ? OWNER_VID : OWNER_CPU;

    rd_tag_pipe #(
        .DEPTH (READ_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign cpu_rvalid = tag_out.valid & (tag_out.owner == OWNER_CPU);
    assign vid_rvalid = tag_out.valid & (tag_out.owner == OWNER_VID);
    assign cpu_rdata  = mem_rdata;
    assign vid_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at READ_LAT=1 and one at READ_LAT=2 driven by the same requests.
module tb_mem_port_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, vid_req;
    logic [15:0] cpu_addr, cpu_wdata, vid_addr;

    logic        cpu_gnt_a, cpu_stall_a, cpu_rvalid_a, vid_gnt_a, vid_rvalid_a, mem_we_a;
    logic [15:0] cpu_rdata_a, vid_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic [2:0]  vid_wait_a;
    logic        cpu_gnt_b, cpu_stall_b, cpu_rvalid_b, vid_gnt_b, vid_rvalid_b, mem_we_b;
    logic [15:0] cpu_rdata_b, vid_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [2:0]  vid_wait_b;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1), .VID_MAX_WAIT(MAXW)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_a), .cpu_stall(cpu_stall_a), .cpu_rvalid(cpu_rvalid_a), .cpu_rdata(cpu_rdata_a),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt_a), .vid_rvalid(vid_rvalid_a),
        .vid_rdata(vid_rdata_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a),
        .mem_rdata(mem_rdata_a), .vid_wait(vid_wait_a)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(2), .VID_MAX_WAIT(MAXW)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_b), .cpu_stall(cpu_stall_b), .cpu_rvalid(cpu_rvalid_b), .cpu_rdata(cpu_rdata_b),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt_b), .vid_rvalid(vid_rvalid_b),
        .vid_rdata(vid_rdata_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
        .mem_rdata(mem_rdata_b), .vid_wait(vid_wait_b)
    );

    // Memories seen by the DUTs: one read-latency stage (a) and two (b).
    logic [15:0] mem_a [65536];
    logic [15:0] mem_b [65536];
    logic [15:0] rd_a, rd_b0, rd_b1;

    always @(posedge clk) begin
        if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
        if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
        rd_a  <= mem_a[mem_addr_a];
        rd_b0 <= mem_b[mem_addr_b];
        rd_b1 <= rd_b0;
    end

    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = rd_b1;

    // Reference model: refused-cycle count, its own memory image, and per-latency return queues.
    typedef struct {
        int          due;
        bit          vid;
        logic [15:0] data;
    } rd_t;

    logic [15:0] ref_mem [65536];
    rd_t         exp_q1[$];
    rd_t         exp_q2[$];
    int          m_wait;
    int          cyc;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ret(input string tag, input int lat, input logic crv, input logic vrv,
                           input logic [15:0] crd, input logic [15:0] vrd);
        bit          e_c, e_v;
        logic [15:0] e_d;
        e_c = 0;
        e_v = 0;
        e_d = '0;
        if (lat == 1 && exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
            e_v = exp_q1[0].vid;
            e_c = !exp_q1[0].vid;
            e_d = exp_q1[0].data;
        end
        if (lat == 2 && exp_q2.size() > 0 && exp_q2[0].due == cyc) begin
            e_v = exp_q2[0].vid;
            e_c = !exp_q2[0].vid;
            e_d = exp_q2[0].data;
        end
        chk({tag, "_cpu_rvalid"}, 32'(crv), 32'(e_c));
        chk({tag, "_vid_rvalid"}, 32'(vrv), 32'(e_v));
        if (e_c) chk({tag, "_cpu_rdata"}, 32'(crd), 32'(e_d));
        if (e_v) chk({tag, "_vid_rdata"}, 32'(vrd), 32'(e_d));
    endtask

    // Called mid-cycle: compare every observable against the rules, then advance the model.
    task automatic check_and_advance();
        bit e_vg, e_cg, e_we, e_st, rd;
        logic [15:0] e_addr;
        rd_t ent;
        if (reset) begin
            exp_q1.delete();
            exp_q2.delete();
            m_wait = 0;
        end
        e_vg   = !reset && vid_req && (!cpu_req || m_wait >= MAXW);
        e_cg   = !reset && cpu_req && !e_vg;
        e_we   = e_cg && cpu_we;
        e_st   = !reset && cpu_req && !e_cg;
        e_addr = e_vg ? vid_addr : cpu_addr;

        chk("vid_gnt_a", 32'(vid_gnt_a), 32'(e_vg));
        chk("cpu_gnt_a", 32'(cpu_gnt_a), 32'(e_cg));
        chk("mem_we_a", 32'(mem_we_a), 32'(e_we));
        chk("cpu_stall_a", 32'(cpu_stall_a), 32'(e_st));
        chk("vid_wait_a", 32'(vid_wait_a), 32'(m_wait));
        chk("vid_gnt_b", 32'(vid_gnt_b), 32'(e_vg));
        chk("cpu_gnt_b", 32'(cpu_gnt_b), 32'(e_cg));
        chk("mem_we_b", 32'(mem_we_b), 32'(e_we));
        if (e_vg || e_cg) begin
            chk("mem_addr_a", 32'(mem_addr_a), 32'(e_addr));
            chk("mem_addr_b", 32'(mem_addr_b), 32'(e_addr));
        end
        if (e_we) chk("mem_wdata_a", 32'(mem_wdata_a), 32'(cpu_wdata));
        chk_ret("ret_a", 1, cpu_rvalid_a, vid_rvalid_a, cpu_rdata_a, vid_rdata_a);
        chk_ret("ret_b", 2, cpu_rvalid_b, vid_rvalid_b, cpu_rdata_b, vid_rdata_b);

        if (exp_q1.size() > 0 && exp_q1[0].due == cyc) void'(exp_q1.pop_front());
        if (exp_q2.size() > 0 && exp_q2[0].due == cyc) void'(exp_q2.pop_front());
        if (!reset) begin
            if (e_vg || !vid_req) m_wait = 0;
            else if (m_wait < MAXW) m_wait++;
            rd = e_vg || (e_cg && !cpu_we);
            if (rd) begin
                ent.vid  = e_vg;
                ent.data = ref_mem[e_addr];
                ent.due  = cyc + 1;
                exp_q1.push_back(ent);
                ent.due  = cyc + 2;
                exp_q2.push_back(ent);
            end
            if (e_we) ref_mem[cpu_addr] = cpu_wdata;
        end
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0;
        vid_req = 0;
        cpu_we  = 0;
    endtask

    initial begin
        logic [15:0] v;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        m_wait   = 0;
        reset    = 1'b1;
        cpu_req  = 0;
        cpu_we   = 0;
        vid_req  = 0;
        cpu_addr = '0;
        vid_addr = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            mem_a[i]   = v;
            mem_b[i]   = v;
            ref_mem[i] = v;
        end
        mem_a[16'h0010] = 16'hBEEF;
        mem_b[16'h0010] = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;

        // Reset state, with requests pending to show grants are held off.
        @(posedge clk);
        #1;
        cpu_req = 1;
        vid_req = 1;
        cycle();
        cycle();
        idle();
        reset = 1'b0;
        cycle();

        // CPU-only read of 0x0010 returning 0xBEEF.
        cpu_req  = 1;
        cpu_addr = 16'h0010;
        cycle();
        idle();
        cycle();
        cycle();
        cycle();

        // Both requesting continuously: four CPU grants then one VID grant, repeating.
        cpu_req  = 1;
        vid_req  = 1;
        cpu_addr = 16'h0040;
        vid_addr = 16'h0041;
        repeat (12) cycle();
        idle();
        cycle();
        cycle();
        chk("t2_wait_cleared", 32'(vid_wait_a), 32'd0);

        // CPU write and VID read of the same address in one cycle.
        cpu_req   = 1;
        cpu_we    = 1;
        cpu_addr  = 16'h0020;
        cpu_wdata = 16'h1234;
        vid_req   = 1;
        vid_addr  = 16'h0020;
        cycle();
        cpu_req = 0;
        cpu_we  = 0;
        cycle();
        idle();
        cycle();
        chk("t3_vid_rdata_b", 32'(vid_rdata_b), 32'h1234);
        cycle();

        // CPU read granted, then reset for three cycles; its return must vanish.
        cpu_req  = 1;
        cpu_addr = 16'h0010;
        cycle();
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        idle();
        repeat (3) cycle();

        // VID refused twice, then withdrawn.
        cpu_req  = 1;
        vid_req  = 1;
        cpu_addr = 16'h0011;
        vid_addr = 16'h0012;
        cycle();
        cycle();
        vid_req = 0;
        cycle();
        chk("t5_wait_zero", 32'(vid_wait_a), 32'd0);
        idle();
        repeat (3) cycle();

        // Alternating CPU and VID reads every cycle.
        for (int i = 0; i < 10; i++) begin
            cpu_req  = (i % 2 == 0);
            vid_req  = (i % 2 == 1);
            cpu_addr = 16'(16'h0100 + i);
            vid_addr = 16'(16'h0200 + i);
            cycle();
        end
        idle();
        repeat (3) cycle();

        // Randomized traffic over a small address window, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = ($urandom_range(0, 2) == 0);
            vid_req   = ($urandom_range(0, 2) != 0);
            cpu_addr  = 16'($urandom_range(0, 15));
            vid_addr  = 16'($urandom_range(0, 15));
            cpu_wdata = 16'($urandom);
            cycle();
        end
        reset = 1'b0;
        idle();
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
